// File: rtl/led_serial_driver_if.sv
`default_nettype none
//==============================================================================
// Module   : led_serial_driver_if
// Purpose  : Pattern input and serial LED-chain outputs of led_serial_driver.
// Revision : 1.0 - initial release
//==============================================================================
interface led_serial_driver_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] led_in;
   logic             ser_data;
   logic             ser_clk;
   logic             ser_latch;
   logic             busy;
   logic             frame_done;

   modport master (
      output led_in,
      input  ser_data, ser_clk, ser_latch, busy, frame_done
   );

   modport slave (
      input  led_in,
      output ser_data, ser_clk, ser_latch, busy, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/led_serial_driver.sv
`default_nettype none
//==============================================================================
// Module   : led_serial_driver
// Purpose  : Serialises the LED pattern MSB first into a 595-style shift/latch
//            chain, on every pattern change and on a periodic refresh.
// Revision : 1.0 - initial release
//==============================================================================
module led_serial_driver #(
   parameter int WIDTH          = 16,
   parameter int CLK_DIV        = 2,
   parameter int REFRESH_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               reset,
   led_serial_driver_if.slave bus
);

   localparam int c_bit_w = (WIDTH > 1)   ? $clog2(WIDTH)   : 1;
   localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_bit_w-1:0] c_bit_max = c_bit_w'(WIDTH - 1);
   localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             r_state,     w_state_next;
   logic [WIDTH-1:0]   r_shift,     w_shift_next;
   logic [WIDTH-1:0]   r_last_sent, w_last_next;
   logic [c_bit_w-1:0] r_bit_cnt,   w_bit_next;
   logic [c_div_w-1:0] r_div_cnt,   w_div_next;
   logic               r_ser_data,  w_data_next;
   logic               r_ser_clk,   w_sclk_next;
   logic               r_ser_latch, w_latch_next;
   logic               r_busy,      w_busy_next;
   logic               r_frame_done, w_done_next;
   logic               r_pending,   w_pending_next;
   logic [WIDTH-1:0]   w_shifted;
   logic               w_trigger;
   logic               w_capture;
   logic               w_refresh_hit;

   assign w_shifted = r_shift << 1;
   assign w_trigger = (bus.led_in != r_last_sent) || r_pending;
   assign w_capture = ((r_state == IDLE) || (r_state == DONE)) && w_trigger;
   assign w_pending_next = w_capture ? 1'b0 : (r_pending | w_refresh_hit);

   always_comb begin
      w_state_next = r_state;
      w_shift_next = r_shift;
      w_last_next  = r_last_sent;
      w_bit_next   = r_bit_cnt;
      w_div_next   = r_div_cnt;
      w_data_next  = r_ser_data;
      w_sclk_next  = r_ser_clk;
      w_latch_next = r_ser_latch;
      w_busy_next  = r_busy;
      w_done_next  = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            w_state_next = IDLE;
            w_busy_next  = 1'b0;
            if (w_trigger) begin
               w_state_next = SHIFT;
               w_shift_next = bus.led_in;
               w_last_next  = bus.led_in;
               w_data_next  = bus.led_in[WIDTH-1];
               w_sclk_next  = 1'b0;
               w_busy_next  = 1'b1;
               w_bit_next   = c_bit_max;
               w_div_next   = '0;
            end
         end
         SHIFT: begin
            if (r_div_cnt == c_div_max) begin
               w_div_next = '0;
               if (!r_ser_clk) begin
                  w_sclk_next = 1'b1;
               end else if (r_bit_cnt == '0) begin
                  w_sclk_next  = 1'b0;
                  w_data_next  = 1'b0;
                  w_latch_next = 1'b1;
                  w_state_next = LATCH;
               end else begin
                  // Data only moves on the falling edge of ser_clk
                  w_sclk_next  = 1'b0;
                  w_shift_next = w_shifted;
                  w_data_next  = w_shifted[WIDTH-1];
                  w_bit_next   = r_bit_cnt - c_bit_w'(1);
               end
            end else begin
               w_div_next = r_div_cnt + c_div_w'(1);
            end
         end
         LATCH: begin
            if (r_div_cnt == c_div_max) begin
               w_div_next   = '0;
               w_latch_next = 1'b0;
               w_busy_next  = 1'b0;
               w_done_next  = 1'b1;
               w_state_next = DONE;
            end else begin
               w_div_next = r_div_cnt + c_div_w'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_shift      <= '0;
         r_last_sent  <= '0;
         r_bit_cnt    <= '0;
         r_div_cnt    <= '0;
         r_ser_data   <= 1'b0;
         r_ser_clk    <= 1'b0;
         r_ser_latch  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_pending    <= 1'b1;
      end else begin
         r_state      <= w_state_next;
         r_shift      <= w_shift_next;
         r_last_sent  <= w_last_next;
         r_bit_cnt    <= w_bit_next;
         r_div_cnt    <= w_div_next;
         r_ser_data   <= w_data_next;
         r_ser_clk    <= w_sclk_next;
         r_ser_latch  <= w_latch_next;
         r_busy       <= w_busy_next;
         r_frame_done <= w_done_next;
         r_pending    <= w_pending_next;
      end
   end

   generate
      if (REFRESH_CYCLES > 0) begin : g_refresh
         localparam int c_ref_w = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
         localparam logic [c_ref_w-1:0] c_ref_max = c_ref_w'(REFRESH_CYCLES - 1);
         logic [c_ref_w-1:0] r_refresh_cnt;
         logic [c_ref_w-1:0] w_refresh_next;

         // Saturates at the terminal count so pending stays requested until served
         always_comb begin
            w_refresh_next = r_refresh_cnt;
            if (w_capture)
               w_refresh_next = '0;
            else if (r_refresh_cnt != c_ref_max)
               w_refresh_next = r_refresh_cnt + c_ref_w'(1);
         end

         assign w_refresh_hit = !w_capture && (w_refresh_next == c_ref_max);

         always_ff @(posedge clk) begin
            if (reset)
               r_refresh_cnt <= '0;
            else
               r_refresh_cnt <= w_refresh_next;
         end
      end else begin : g_no_refresh
         assign w_refresh_hit = 1'b0;
      end
   endgenerate

   assign bus.ser_data   = r_ser_data;
   assign bus.ser_clk    = r_ser_clk;
   assign bus.ser_latch  = r_ser_latch;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
